// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// prefetch buffer entry layout and the NOP shown while no instruction is valid.
package fetch_pkg;

  localparam int          FETCH_ADDR_W = 32;
  localparam logic [31:0] NOP_INSTR    = 32'hE1A00000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]             instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the decode path.
// IMemReq/IMemAck: request is held with a stable IMemAddr until the cycle IMemAck=1,
// which completes the transfer with IMemRData; InstrValid/InstrReady: the head
// instruction transfers on every cycle both are 1, and PCSrc only counts in such a cycle.
interface instr_fetch_unit_if #(parameter int ADDR_W = 32);

  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemAck;
  logic [31:0]       IMemRData;
  logic [31:0]       Instr;
  logic [ADDR_W-1:0] InstrPC;
  logic [ADDR_W-1:0] PCPlus8;
  logic              InstrValid;
  logic              InstrReady;
  logic              PCSrc;
  logic [ADDR_W-1:0] BranchTarget;

  modport master (
    output IMemReq, IMemAddr, Instr, InstrPC, PCPlus8, InstrValid,
    input  IMemAck, IMemRData, InstrReady, PCSrc, BranchTarget
  );

  modport slave (
    input  IMemReq, IMemAddr, Instr, InstrPC, PCPlus8, InstrValid,
    output IMemAck, IMemRData, InstrReady, PCSrc, BranchTarget
  );

endinterface

// File: rtl/instr_fetch_unit_buffer.sv
// Small FIFO of fetched {instr, pc} entries; flush wins over push, and a push
// into a full buffer is accepted only when the head is popped in the same cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               data_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only read while count_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory request, a small prefetch buffer feeding
// decode, and branch redirect that flushes the buffer and drops an in-flight fetch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic                CLK,
  input  logic                Reset,
  instr_fetch_unit_if.master  bus,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic [ADDR_W-1:0] instr_pc;
  logic [CNT_W-1:0]  buf_count, count_after;
  fetch_entry_t      head, push_entry;
  logic              buf_full, buf_empty;
  logic              accept, consume, redirect, push, pop, has_space, new_req;

  assign accept      = bus.IMemAck && (state_q != S_IDLE);
  assign consume     = !buf_empty && bus.InstrReady;
  assign redirect    = consume && bus.PCSrc;
  assign push        = accept && (state_q == S_REQ) && !redirect;
  assign pop         = consume && !redirect;
  assign count_after = redirect ? '0 : buf_count + CNT_W'(push) - CNT_W'(pop);
  assign has_space   = count_after < CNT_W'(BUF_DEPTH);
  assign push_entry  = '{instr: bus.IMemRData, pc: fetch_pc_q};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect)  fetch_pc_d = bus.BranchTarget & ~ADDR_W'(3);
    else if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    unique case (state_q)
      S_IDLE:    if (!buf_full || consume) state_d = S_REQ;
      // Without an ack the request cannot be withdrawn, so a redirect waits it out.
      S_REQ: begin
        if (accept)        state_d = has_space ? S_REQ : S_IDLE;
        else if (redirect) state_d = S_DISCARD;
      end
      S_DISCARD: if (accept) state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  // IMemAddr only moves when a fresh request starts, keeping it stable through S_DISCARD.
  assign new_req = (state_d == S_REQ) && ((state_q == S_IDLE) || accept);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (new_req) req_addr_q <= fetch_pc_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
    .clk_i   (CLK),
    .rst_ni  (Reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign instr_pc       = buf_empty ? fetch_pc_q : head.pc;
  assign bus.IMemReq    = (state_q != S_IDLE);
  assign bus.IMemAddr   = req_addr_q;
  assign bus.InstrValid = !buf_empty;
  assign bus.Instr      = buf_empty ? NOP_INSTR : head.instr;
  assign bus.InstrPC    = instr_pc;
  assign bus.PCPlus8    = instr_pc + ADDR_W'(8);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random-latency memory responder, directed branch/reset
// scenarios and a queue-based model of the fetched instruction stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] dbg_state;

  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- shared state ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] exp_q[$];           // {instr, pc} expected at decode, oldest first
  logic [31:0] model_pc   = 32'h0;
  bit          discard    = 1'b0;
  bit          armed      = 1'b0;
  bit          rst_prev   = 1'b0;
  bit          wait_prev  = 1'b0;
  logic [31:0] addr_prev  = 32'h0;
  logic [31:0] cons_log[$];        // InstrPC of every consumed instruction
  logic [31:0] hs_log[$];          // IMemAddr of every completed memory handshake
  int          lat_min = 1, lat_max = 1, mem_cnt = 0;
  bit          ovr_en = 1'b0, ovr_ack = 1'b0;
  logic [31:0] ovr_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
  endtask

  task automatic wait_cons(input int n, input int budget);
    int c = 0;
    while (cons_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (cons_log.size() < n) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_cons: got %0d consumed, required %0d", cons_log.size(), n);
    end
  endtask

  task automatic wait_branch_slot(input string name, input int budget);
    int c = 0;
    while (!(bus.IMemReq && bus.InstrValid) && c < budget) begin
      tick();
      c++;
    end
    if (!(bus.IMemReq && bus.InstrValid)) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no cycle with request and valid instruction within %0d cycles", name, budget);
    end
  endtask

  // Instruction memory: acks after a random number of cycles with IMemReq high.
  always @(posedge CLK) begin
    #1;
    if (ovr_en) begin
      bus.IMemAck   = ovr_ack;
      bus.IMemRData = ovr_data;
      mem_cnt       = 0;
    end else if (Reset && bus.IMemReq) begin
      if (mem_cnt == 0) mem_cnt = $urandom_range(lat_max, lat_min);
      mem_cnt--;
      bus.IMemAck   = (mem_cnt == 0);
      bus.IMemRData = $urandom;
    end else begin
      bus.IMemAck = 1'b0;
      mem_cnt     = 0;
    end
  end

  // ---------------- scoreboard / model ----------------
  always @(negedge CLK) begin
    bit consume, redirect, hs;
    if (armed) begin
      if (rst_prev) begin
        check("rst_req",   32'(bus.IMemReq), 32'h0);
        check("rst_addr",  bus.IMemAddr, 32'h0);
        check("rst_valid", 32'(bus.InstrValid), 32'h0);
        check("rst_instr", bus.Instr, NOP);
        check("rst_pc",    bus.InstrPC, 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
      end
      check("valid", 32'(bus.InstrValid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("instr",    bus.Instr,   exp_q[0][63:32]);
        check("instr_pc", bus.InstrPC, exp_q[0][31:0]);
        check("pc_plus8", bus.PCPlus8, exp_q[0][31:0] + 32'd8);
      end
      if (wait_prev) begin
        check("req_held",  32'(bus.IMemReq), 32'h1);
        check("addr_held", bus.IMemAddr, addr_prev);
      end
      if (exp_q.size() >= DEPTH) check("no_req_when_full", 32'(bus.IMemReq), 32'h0);
    end

    if (!Reset) begin
      exp_q.delete();
      model_pc  = 32'h0;
      discard   = 1'b0;
      wait_prev = 1'b0;
      rst_prev  = 1'b1;
      armed     = 1'b1;
    end else if (armed) begin
      rst_prev = 1'b0;
      consume  = (exp_q.size() != 0) && bus.InstrReady;
      redirect = consume && bus.PCSrc;
      hs       = bus.IMemReq && bus.IMemAck;
      if (hs) hs_log.push_back(bus.IMemAddr);
      if (consume) begin
        cons_log.push_back(bus.InstrPC);
        void'(exp_q.pop_front());
      end
      if (hs) begin
        if (discard || redirect) begin
          discard = 1'b0;
        end else begin
          check("fetch_addr", bus.IMemAddr, model_pc);
          exp_q.push_back({bus.IMemRData, model_pc});
          model_pc = model_pc + 32'd4;
        end
      end
      if (redirect) begin
        exp_q.delete();
        model_pc = bus.BranchTarget & ~32'h3;
        if (bus.IMemReq && !bus.IMemAck) discard = 1'b1;
      end
      wait_prev = bus.IMemReq && !bus.IMemAck;
      addr_prev = bus.IMemAddr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.IMemAck      = 1'b0;
    bus.IMemRData    = 32'h0;
    bus.InstrReady   = 1'b1;
    bus.PCSrc        = 1'b0;
    bus.BranchTarget = 32'h0;

    // 1: single-cycle memory, decode always ready
    tick(3);
    Reset = 1'b1;
    cons_log.delete();
    hs_log.delete();
    wait_cons(4, 40);
    if (cons_log.size() >= 4) begin
      check("p1_pc0", cons_log[0], 32'h0);
      check("p1_pc1", cons_log[1], 32'h4);
      check("p1_pc2", cons_log[2], 32'h8);
      check("p1_pc3", cons_log[3], 32'hC);
      check("p1_hs0", hs_log[0], 32'h0);
    end
    tick(10);

    // 2: five-cycle memory latency
    lat_min = 5;
    lat_max = 5;
    cons_log.delete();
    wait_cons(3, 60);
    if (cons_log.size() >= 3) check("p2_seq", cons_log[2] - cons_log[1], 32'h4);

    // 3: decode stalled, buffer fills and fetch stops
    lat_min = 1;
    lat_max = 1;
    tick(5);
    bus.InstrReady = 1'b0;
    tick(10);
    check("p3_req_idle", 32'(bus.IMemReq), 32'h0);
    check("p3_valid",    32'(bus.InstrValid), 32'h1);
    check("p3_depth",    32'(exp_q.size()), 32'h2);
    cons_log.delete();
    bus.InstrReady = 1'b1;
    wait_cons(6, 30);
    if (cons_log.size() >= 6) check("p3_resume", cons_log[5] - cons_log[0], 32'h14);

    // 4: branch while the fetch of 0x10 is in flight
    lat_min = 4;
    lat_max = 4;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (bus.IMemReq && bus.IMemAddr == 32'h10 && bus.InstrValid) break;
      tick();
    end
    check("p4_setup", bus.IMemAddr, 32'h10);
    hs_log.delete();
    cons_log.delete();
    bus.PCSrc        = 1'b1;
    bus.BranchTarget = 32'h103;
    tick();
    bus.PCSrc = 1'b0;
    wait_cons(2, 60);
    if (cons_log.size() >= 2 && hs_log.size() >= 2) begin
      check("p4_br_pc",  cons_log[0], 32'hC);
      check("p4_tgt_pc", cons_log[1], 32'h100);
      check("p4_hs0",    hs_log[0], 32'h10);
      check("p4_hs1",    hs_log[1], 32'h100);
    end

    // 5: branch in the same cycle as an ack
    lat_min = 1;
    lat_max = 1;
    do_reset();
    tick(6);
    wait_branch_slot("p5_setup", 40);
    hs_log.delete();
    cons_log.delete();
    bus.PCSrc        = 1'b1;
    bus.BranchTarget = 32'h200;
    tick();
    bus.PCSrc = 1'b0;
    wait_cons(2, 30);
    if (cons_log.size() >= 2 && hs_log.size() >= 2) begin
      check("p5_tgt_pc", cons_log[1], 32'h200);
      check("p5_hs1",    hs_log[1], 32'h200);
    end

    // PC wrap at the top of the address space
    tick(4);
    wait_branch_slot("wrap_setup", 40);
    cons_log.delete();
    bus.PCSrc        = 1'b1;
    bus.BranchTarget = 32'hFFFF_FFFE;
    tick();
    bus.PCSrc = 1'b0;
    wait_cons(3, 30);
    if (cons_log.size() >= 3) begin
      check("wrap_top",  cons_log[1], 32'hFFFF_FFFC);
      check("wrap_zero", cons_log[2], 32'h0);
    end

    // 6: reset mid-request with a stray ack around the reset
    lat_min = 6;
    lat_max = 6;
    do_reset();
    tick(3);
    ovr_data = 32'hDEAD_BEEF;
    ovr_ack  = 1'b1;
    ovr_en   = 1'b1;
    Reset    = 1'b0;
    tick(2);
    Reset = 1'b1;
    cons_log.delete();
    hs_log.delete();
    tick();
    ovr_ack = 1'b0;
    tick();
    lat_min = 1;
    lat_max = 1;
    ovr_en  = 1'b0;
    wait_cons(2, 30);
    if (cons_log.size() >= 2 && hs_log.size() >= 1) begin
      check("p6_pc0", cons_log[0], 32'h0);
      check("p6_pc1", cons_log[1], 32'h4);
      check("p6_hs0", hs_log[0], 32'h0);
    end

    // Random traffic: variable latency, stalls and branches
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      bus.InstrReady   = ($urandom_range(3, 0) != 0);
      bus.PCSrc        = ($urandom_range(7, 0) == 0);
      bus.BranchTarget = $urandom;
      tick();
    end
    bus.PCSrc      = 1'b0;
    bus.InstrReady = 1'b1;
    tick(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
